rca_word_scheduler: RTL
=======================

// Module: rca_word_scheduler
// PURPOSE
//  Shares one external 8-bit ripple-carry adder between N_REQ requesters.
//  Each requester asks for one word add of W = 8*SLICES bits.
//  A round-robin arbiter picks one requester. The FSM then feeds the shared adder
//  one byte slice per cycle, LSB slice first, and keeps the carry in a register between slices.
//  Sits between the client blocks and the single shared adder instance.
// PARAMETERS
//  N_REQ   4  number of requesters (>=2)
//  SLICES  4  8-bit slices per word; word width W = 8*SLICES
// PORTS
//  clk       in   1          clock, rising edge
//  reset     in   1          asynchronous, active-high reset
//  req       in   N_REQ      request per requester; held high until ack
//  a         in   N_REQ*W    operand A; requester i uses a[i*W +: W]
//  b         in   N_REQ*W    operand B; requester i uses b[i*W +: W]
//  cin       in   N_REQ      carry-in per requester
//  ack       out  N_REQ      one-cycle pulse to the served requester, in the same cycle as done
//  result    out  W          sum of the last completed add
//  cout      out  1          carry-out of the last completed add
//  done      out  1          one-cycle pulse; result and cout are valid from this cycle
//  busy      out  1          high in the ADD and DONE states
//  grant_id  out  $clog2(N_REQ)  index of the current or last granted requester
//  add_x     out  8          operand slice driven to the shared adder
//  add_y     out  8          operand slice driven to the shared adder
//  add_cin   out  1          carry-in driven to the shared adder
//  add_sum   in   8          sum returned by the adder (combinational)
//  add_cout  in   1          carry-out returned by the adder (combinational)
// BEHAVIOUR
//  Reset values: state IDLE. All outputs 0. Round-robin pointer 0. Internal regs 0.
//  States: IDLE -> ADD -> DONE -> IDLE.
//  IDLE, at each rising edge:
//   - If any req bit is high, grant the first requester with req high.
//   - Search order starts at the pointer and wraps modulo N_REQ.
//   - On grant: latch that requester's a, b and cin into internal regs.
//   - On grant: grant_id <= winner; slice counter k <= 0; pointer <= (winner+1) mod N_REQ.
//   - On grant: go to ADD. With no req high, stay in IDLE.
//  ADD, one slice per cycle, k = 0 .. SLICES-1:
//   - add_x = A[8k +: 8]; add_y = B[8k +: 8].
//   - add_cin = latched cin when k = 0, else the carry register.
//   - At the edge: result[8k +: 8] <= add_sum; carry register <= add_cout.
//   - When k = SLICES-1: cout <= add_cout and go to DONE. Otherwise k <= k+1.
//  DONE, one cycle: done = 1 and ack[grant_id] = 1. Then go to IDLE.
//  Outside ADD, add_x, add_y and add_cin are driven 0.
//  Latency:
//   - Request sampled at edge t.
//   - ADD occupies cycles t+1 .. t+SLICES.
//   - done/ack are high in cycle t+SLICES+1.
//   - The next grant can be sampled at the edge that ends the DONE cycle + 1 (from IDLE).
//  Throughput: one transaction per SLICES+2 cycles.
//  Arithmetic: result = (A + B + cin) mod 2^W. cout = bit W of the full sum.
//  result, cout and grant_id hold their values until the next grant overwrites them.
//  Partial slices of result are visible during ADD. Clients read result only at done.
//  Boundary rules:
//   - req or operands change after the grant: ignored. The latched copy is used.
//   - req drops mid-operation: the add still completes and ack still pulses.
//   - req high again in the ack cycle (req not yet seen low): treated as a new request
//     at the next IDLE edge. Clients drop req in the ack cycle.
//   - Simultaneous requests: the round-robin rule alone decides.
//     A requester that holds req waits at most N_REQ-1 other transactions.
//   - reset mid-operation: immediate return to reset values; no ack or done for the aborted add.
//   - All req low: idle indefinitely; busy = 0.
// TESTING
//  T1: req[0] only, a0=0x000000FF, b0=0x00000001, cin0=0 -> result=0x00000100, cout=0;
//      done and ack[0] high exactly 5 cycles after the sampling edge.
//  T2: req[2], a2=0xFFFFFFFF, b2=0x00000000, cin2=1 -> result=0x00000000, cout=1;
//      add_cin=1 in all 4 ADD cycles.
//  T3: req=4'b1111 held, each requester dropping req on its ack -> grant_id order 0,1,2,3.
//      Then req=4'b0101 -> order 0,2.
//  T4: req[0] and req[1] held continuously -> grants alternate 0,1,0,1.
//      Exactly 6 cycles between consecutive done pulses.
//  T5: reset pulsed during ADD slice k=2 of a req[3] add -> all outputs 0 asynchronously; no ack.
//      After release, req[1] alone is granted with pointer reset, grant_id=1.
//  T6: req[1] dropped and a1 changed during ADD -> result uses the latched operands; ack[1] still pulses.

Source files
------------

// File: rtl/rca_word_scheduler.sv
// -----------------------------------------------------------------------------
// rca_word_scheduler
//
// Time-shares one external 8-bit ripple-carry adder between N_REQ requesters.
// A round-robin arbiter picks one pending requester while idle, its operands
// are latched, and the word add is then streamed through the shared adder one
// byte slice per cycle, least significant slice first. The carry is kept in a
// register between slices. After the last slice a single DONE cycle pulses
// done_o together with the served requester's ack_o bit.
//
// Ports
//   clk_i       clock, rising edge
//   reset_i     asynchronous active-high reset
//   req_i       per-requester request, held high until its ack
//   a_i, b_i    per-requester operands, requester i uses [i*W +: W]
//   cin_i       per-requester carry-in
//   ack_o       one-cycle pulse to the served requester (same cycle as done_o)
//   result_o    sum of the last completed add (partial slices visible in ADD)
//   cout_o      carry-out of the last completed add
//   done_o      one-cycle completion pulse
//   busy_o      high while in ADD or DONE
//   grant_id_o  index of the current or last granted requester
//   add_x_o     operand A slice to the shared adder (0 outside ADD)
//   add_y_o     operand B slice to the shared adder (0 outside ADD)
//   add_cin_o   carry-in to the shared adder (0 outside ADD)
//   add_sum_i   8-bit sum from the shared adder (combinational)
//   add_cout_i  carry-out from the shared adder (combinational)
// -----------------------------------------------------------------------------
module rca_word_scheduler #(
    parameter int N_REQ  = 4,
    parameter int SLICES = 4,
    localparam int W     = 8 * SLICES,
    localparam int IDW   = $clog2(N_REQ),
    localparam int KW    = (SLICES > 1) ? $clog2(SLICES) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [N_REQ-1:0]     req_i,
    input  logic [N_REQ*W-1:0]   a_i,
    input  logic [N_REQ*W-1:0]   b_i,
    input  logic [N_REQ-1:0]     cin_i,
    output logic [N_REQ-1:0]     ack_o,
    output logic [W-1:0]         result_o,
    output logic                 cout_o,
    output logic                 done_o,
    output logic                 busy_o,
    output logic [IDW-1:0]       grant_id_o,
    output logic [7:0]           add_x_o,
    output logic [7:0]           add_y_o,
    output logic                 add_cin_o,
    input  logic [7:0]           add_sum_i,
    input  logic                 add_cout_i
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   grant_id_q, grant_id_d;
    logic [KW-1:0]    k_q, k_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     result_q, result_d;
    logic             cin_q, cin_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;

    // -------------------------------------------------------------------------
    // Round-robin arbiter.
    // Position gi of the rotated view corresponds to requester (ptr + gi) mod
    // N_REQ, so the first set bit of req_rot is the winner. The wrap is done
    // with a single conditional subtract because ptr + gi < 2*N_REQ.
    // -------------------------------------------------------------------------
    logic [IDW-1:0]   rot_idx [N_REQ];
    logic [N_REQ-1:0] req_rot;
    logic [IDW-1:0]   winner;
    logic             any_req;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [IDW:0] sum;
            assign sum         = {1'b0, ptr_q} + (IDW+1)'(gi);
            assign rot_idx[gi] = (sum >= (IDW+1)'(N_REQ))
                               ? IDW'(sum - (IDW+1)'(N_REQ))
                               : sum[IDW-1:0];
            assign req_rot[gi] = req_i[rot_idx[gi]];
        end
    endgenerate

    // Scanning from the far end down lets the nearest requester overwrite
    // any farther one, giving the first match in search order.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                winner  = rot_idx[i];
                any_req = 1'b1;
            end
        end
    end

    // Operands of the candidate winner, captured only on a grant.
    logic [W-1:0] a_sel;
    logic [W-1:0] b_sel;
    assign a_sel = a_i[winner*W +: W];
    assign b_sel = b_i[winner*W +: W];

    // -------------------------------------------------------------------------
    // Shared adder drive
    // -------------------------------------------------------------------------
    logic       in_add;
    logic [7:0] a_slice;
    logic [7:0] b_slice;

    assign in_add  = (state_q == S_ADD);
    assign a_slice = a_q[k_q*8 +: 8];
    assign b_slice = b_q[k_q*8 +: 8];

    assign add_x_o   = in_add ? a_slice : 8'd0;
    assign add_y_o   = in_add ? b_slice : 8'd0;
    // The requester's carry-in enters only at the first slice; afterwards the
    // ripple continues from the previous slice's carry-out.
    assign add_cin_o = in_add ? ((k_q == '0) ? cin_q : carry_q) : 1'b0;

    // -------------------------------------------------------------------------
    // Status outputs, decoded from registered state so they are glitch-free
    // and all zero while reset is applied.
    // -------------------------------------------------------------------------
    assign done_o     = (state_q == S_DONE);
    assign busy_o     = (state_q == S_ADD) || (state_q == S_DONE);
    assign result_o   = result_q;
    assign cout_o     = cout_q;
    assign grant_id_o = grant_id_q;

    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_ack
            assign ack_o[gi] = (state_q == S_DONE) && (grant_id_q == IDW'(gi));
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_id_d = grant_id_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        cin_d      = cin_q;
        carry_d    = carry_q;
        result_d   = result_q;
        cout_d     = cout_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    a_d        = a_sel;
                    b_d        = b_sel;
                    cin_d      = cin_i[winner];
                    grant_id_d = winner;
                    k_d        = '0;
                    // Pointer moves just past the winner so it becomes the
                    // lowest priority for the next arbitration.
                    ptr_d      = (winner == IDW'(N_REQ - 1)) ? '0 : winner + 1'b1;
                    state_d    = S_ADD;
                end
            end

            S_ADD: begin
                result_d[k_q*8 +: 8] = add_sum_i;
                carry_d              = add_cout_i;
                if (k_q == KW'(SLICES - 1)) begin
                    cout_d  = add_cout_i;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            grant_id_q <= '0;
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            carry_q    <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_id_q <= grant_id_d;
            k_q        <= k_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cin_q      <= cin_d;
            carry_q    <= carry_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
        end
    end

endmodule
